// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader_pkg
//  Shared definitions for the RAM burst reader slice.
//  - state_t      : burst reader FSM state encoding
//  - FIFO_DEPTH   : number of entries in the output skid FIFO
//  - FIFO_CNT_W   : width of the FIFO occupancy count (0..FIFO_DEPTH)
package ram_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

endpackage : ram_burst_reader_pkg

// File: rtl/ram_burst_reader_stream_skid_fifo.sv
// stream_skid_fifo
//  Two-entry FIFO that buffers RAM read data in front of the stream output.
//  A push and a pop in the same cycle are allowed even when full.
//  Ports:
//   Clock, Reset   clock and synchronous active-high reset
//   iPush, iData   write request and write data
//   iPop           read request (ignored when empty)
//   oData          head entry (stable until popped)
//   oFull, oEmpty  occupancy flags
//   oCount         number of stored entries
module stream_skid_fifo
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPush,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iPop,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic [FIFO_CNT_W-1:0] oCount
);

    localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [FIFO_CNT_W-1:0] count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Qualify push/pop: pop needs data, push needs room unless a pop frees a slot.
    always_comb begin
        do_pop_s  = iPop & (count_r != {FIFO_CNT_W{1'b0}});
        do_push_s = iPush & ((count_r != FULL_CNT) | do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= {FIFO_CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= iData;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
                2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign oData  = mem_r[rd_ptr_r];
    assign oFull  = (count_r == FULL_CNT);
    assign oEmpty = (count_r == {FIFO_CNT_W{1'b0}});
    assign oCount = count_r;

endmodule : stream_skid_fifo

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//  Reads iLength consecutive words starting at iBaseAddr from a RAM with a
//  registered (1-cycle latency) read port and streams them out over a
//  valid/ready handshake at up to one word per cycle.
//  Ports:
//   Clock, Reset             clock and synchronous active-high reset
//   iStart, iBaseAddr,       burst request, captured only while idle
//   iLength                  (iLength == 0 is an empty burst)
//   oReadAddress, iRamData   RAM read address / data returned one cycle later
//   oData, oValid, iReady    output stream
//   oBusy, oDone             burst in progress / one-cycle completion pulse
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddr,
    input  logic [ADDR_WIDTH-1:0] iLength,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [DATA_WIDTH-1:0] iRamData,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oValid,
    input  logic                  iReady,
    output logic                  oBusy,
    output logic                  oDone
);

    localparam logic [FIFO_CNT_W:0] CREDIT_LIMIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] remaining_r;
    logic                  inflight_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FIFO_CNT_W-1:0] fifo_count_s;
    logic [DATA_WIDTH-1:0] fifo_data_s;
    logic [FIFO_CNT_W:0]   occupancy_s;
    logic                  transfer_s;
    logic                  issue_s;
    logic                  last_issue_s;
    logic                  last_xfer_s;

    // Credit logic: buffered words plus the read in flight must never exceed
    // the FIFO depth, counting a word leaving this cycle as freed space.
    always_comb begin
        transfer_s  = ~fifo_empty_s & iReady;
        occupancy_s = {1'b0, fifo_count_s} + {{FIFO_CNT_W{1'b0}}, inflight_r};
        if (state_r == ST_READ) begin
            if (occupancy_s < CREDIT_LIMIT) begin
                issue_s = 1'b1;
            end else if ((occupancy_s == CREDIT_LIMIT) && transfer_s && !(fifo_full_s && inflight_r)) begin
                issue_s = 1'b1;
            end else begin
                issue_s = 1'b0;
            end
        end else begin
            issue_s = 1'b0;
        end
        last_issue_s = issue_s & (remaining_r == ADDR_WIDTH'(1));
        // Final word leaves when it is the only one left and nothing is in flight.
        last_xfer_s  = transfer_s & (fifo_count_s == FIFO_CNT_W'(1)) & ~inflight_r;
    end

    // Burst FSM with address, remaining count, in-flight flag and status outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {ADDR_WIDTH{1'b0}};
            inflight_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            case (state_r)
                ST_IDLE: begin
                    if (iStart) begin
                        addr_r      <= iBaseAddr;
                        remaining_r <= iLength;
                        busy_r      <= 1'b1;
                        if (iLength == {ADDR_WIDTH{1'b0}}) begin
                            state_r <= ST_FINISH;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_READ;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                ST_READ: begin
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    if (issue_s) begin
                        remaining_r <= remaining_r - ADDR_WIDTH'(1);
                        // Keep the last issued address on the bus once the burst is fully issued.
                        if (last_issue_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            addr_r <= addr_r + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    busy_r <= 1'b1;
                    if (last_xfer_s) begin
                        state_r <= ST_FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    stream_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .Clock  (Clock),
        .Reset  (Reset),
        .iPush  (inflight_r),
        .iData  (iRamData),
        .iPop   (transfer_s),
        .oData  (fifo_data_s),
        .oFull  (fifo_full_s),
        .oEmpty (fifo_empty_s),
        .oCount (fifo_count_s)
    );

    assign oReadAddress = addr_r;
    assign oData        = fifo_data_s;
    assign oValid       = ~fifo_empty_s;
    assign oBusy        = busy_r;
    assign oDone        = done_r;

endmodule : ram_burst_reader

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
//  Scoreboard bench: each burst request pushes its expected words
//  (RAM[a] = 16'hA000 + a, a = base + i mod 256) into a queue; an independent
//  monitor pops and compares on every handshake, checks data stability
//  during stalls and matches every oDone against an outstanding burst.
module tb_ram_burst_reader;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic [7:0]  iBaseAddr;
    logic [7:0]  iLength;
    logic [7:0]  oReadAddress;
    logic [15:0] iRamData;
    logic [15:0] oData;
    logic        oValid;
    logic        iReady;
    logic        oBusy;
    logic        oDone;

    ram_burst_reader #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iBaseAddr    (iBaseAddr),
        .iLength      (iLength),
        .oReadAddress (oReadAddress),
        .iRamData     (iRamData),
        .oData        (oData),
        .oValid       (oValid),
        .iReady       (iReady),
        .oBusy        (oBusy),
        .oDone        (oDone)
    );

    // Clock generation.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // RAM model with registered read.
    logic [15:0] ram [0:255];
    always @(posedge Clock) iRamData <= ram[oReadAddress];

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_q [$];
    int          pending_done = 0;
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] held = 16'h0000;
    int          ready_mode = 3;
    int          pat_idx = 0;
    logic [5:0]  ready_pat = 6'b101001;  // bit0 first: 1,0,0,1,0,1

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready driver, updated just after each rising edge.
    always @(posedge Clock) begin
        #1;
        case (ready_mode)
            0: iReady = 1'b1;
            1: begin
                iReady  = ready_pat[pat_idx];
                pat_idx = (pat_idx + 1) % 6;
            end
            2: iReady = ($urandom_range(0, 3) != 0);
            default: iReady = 1'b0;
        endcase
    end

    // Monitor: compares handshakes and done pulses against the scoreboard.
    always @(negedge Clock) begin
        if (!mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", {31'b0, oValid}, 32'd1);
                check("stall_data_held", {16'b0, oData}, {16'b0, held});
            end
            if (oValid && iReady) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_word: got %0h expected none", oData);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("stream_data", {16'b0, oData}, {16'b0, e});
                end
            end
            stall_prev = oValid && !iReady;
            held       = oData;
            if (oDone) begin
                if (pending_done == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_done: got 1 expected 0");
                end else begin
                    pending_done--;
                    check("done_all_words_out", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    // Issue one burst and wait (bounded) for its completion pulse.
    task automatic run_burst(input logic [7:0] base, input logic [7:0] len,
                             input bit chk_timing, input bit restart);
        int cyc;
        int first_v;
        @(posedge Clock);
        #2;
        iStart    = 1'b1;
        iBaseAddr = base;
        iLength   = len;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(16'hA000 + {8'h00, 8'(int'(base) + i)});
        end
        pending_done++;
        @(posedge Clock);
        #2;
        iStart = 1'b0;
        cyc     = 0;
        first_v = -1;
        @(negedge Clock);
        while (!oDone && cyc < 400) begin
            if (oValid && first_v < 0) first_v = cyc;
            if (restart && cyc == 2) begin
                iStart    = 1'b1;
                iBaseAddr = 8'h80;
                iLength   = 8'd3;
            end
            if (restart && cyc == 3) iStart = 1'b0;
            @(negedge Clock);
            cyc++;
        end
        check("done_seen", {31'b0, oDone}, 32'd1);
        if (len == 8'd0) begin
            check("empty_done_cycle", 32'(cyc), 32'd0);
            check("empty_busy", {31'b0, oBusy}, 32'd1);
            check("empty_no_valid", {31'b0, oValid}, 32'd0);
        end else if (chk_timing) begin
            check("first_valid_cycle", 32'(first_v), 32'd2);
            check("done_cycle", 32'(cyc), 32'(int'(len) + 2));
        end
        @(negedge Clock);
        check("idle_busy", {31'b0, oBusy}, 32'd0);
        check("idle_done", {31'b0, oDone}, 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_matched", 32'(pending_done), 32'd0);
        if (restart) begin
            repeat (12) @(negedge Clock);
            check("restart_ignored_busy", {31'b0, oBusy}, 32'd0);
            check("restart_ignored_valid", {31'b0, oValid}, 32'd0);
        end
    endtask

    // Hang guard.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence.
    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 16'hA000 + 16'(a);
        Reset     = 1'b1;
        iStart    = 1'b0;
        iBaseAddr = 8'h00;
        iLength   = 8'h00;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_valid", {31'b0, oValid}, 32'd0);
        check("reset_busy", {31'b0, oBusy}, 32'd0);
        check("reset_done", {31'b0, oDone}, 32'd0);
        check("reset_addr", {24'b0, oReadAddress}, 32'd0);
        check("reset_data", {16'b0, oData}, 32'd0);
        @(posedge Clock);
        #2;
        Reset  = 1'b0;
        mon_en = 1'b1;

        ready_mode = 0;
        run_burst(8'h10, 8'd4, 1'b1, 1'b0);
        run_burst(8'hFE, 8'd4, 1'b1, 1'b0);
        pat_idx    = 0;
        ready_mode = 1;
        run_burst(8'h20, 8'd8, 1'b0, 1'b0);
        ready_mode = 0;
        run_burst(8'h33, 8'd0, 1'b1, 1'b0);
        run_burst(8'h50, 8'd6, 1'b1, 1'b1);

        // Reset with two words buffered and the consumer stalled.
        ready_mode = 3;
        @(posedge Clock);
        #2;
        iStart    = 1'b1;
        iBaseAddr = 8'h40;
        iLength   = 8'd6;
        @(posedge Clock);
        #2;
        iStart = 1'b0;
        repeat (5) @(negedge Clock);
        check("prereset_valid", {31'b0, oValid}, 32'd1);
        check("prereset_head", {16'b0, oData}, 32'h0000A040);
        mon_en = 1'b0;
        Reset  = 1'b1;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        @(negedge Clock);
        check("abort_valid", {31'b0, oValid}, 32'd0);
        check("abort_busy", {31'b0, oBusy}, 32'd0);
        check("abort_done", {31'b0, oDone}, 32'd0);
        exp_q.delete();
        pending_done = 0;
        mon_en       = 1'b1;
        ready_mode   = 0;
        run_burst(8'h00, 8'd2, 1'b1, 1'b0);

        // Randomized bursts under random backpressure.
        ready_mode = 2;
        run_burst(8'hF5, 8'd20, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            run_burst(8'($urandom_range(0, 255)), 8'($urandom_range(1, 24)), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_ram_burst_reader
